// File: rtl/pcihellocore_led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer.
package pcihellocore_led_seq_pkg;

  localparam logic [3:0] REG_CTRL       = 4'd0;
  localparam logic [3:0] REG_STATUS     = 4'd1;
  localparam logic [3:0] REG_PERIOD     = 4'd2;
  localparam logic [3:0] REG_LENGTH     = 4'd3;
  localparam logic [3:0] REG_TABLE_BASE = 4'd8;

  localparam int unsigned CTRL_RUN_BIT     = 0;
  localparam int unsigned CTRL_LOOP_BIT    = 1;
  localparam int unsigned STATUS_BUSY_BIT  = 0;
  localparam int unsigned STATUS_DONE_BIT  = 1;
  localparam int unsigned STATUS_INDEX_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DWELL
  } seq_state_e;

endpackage

// File: rtl/pcihellocore_led_seq_timer.sv
// Loadable down-counter timing the dwell between pattern steps.
module pcihellocore_led_seq_timer #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (enable && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // Flags the count reaching 0 on this cycle's update, so the final
  // dwell cycle can hand straight over to the next write.
  assign zero = (count_d == '0);

endmodule

// File: rtl/pcihellocore_led_sequencer.sv
// LED pattern sequencer: host-loaded table replayed into the PIO slave.
module pcihellocore_led_sequencer
  import pcihellocore_led_seq_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned PERIOD_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        s_address,
  input  logic              s_chipselect,
  input  logic              s_write_n,
  input  logic [31:0]       s_writedata,
  output logic [31:0]       s_readdata,
  output logic [1:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [DATA_W-1:0] m_writedata,
  input  logic              m_waitrequest,
  output logic              busy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LEN_W = $clog2(DEPTH + 1);

  seq_state_e        state_q, state_d;
  logic              run_q, run_d;
  logic              loop_q, loop_d;
  logic              done_q, done_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [LEN_W-1:0]  length_q, length_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] table_q [DEPTH];
  logic [DATA_W-1:0] table_d [DEPTH];

  logic                host_wr, table_hit, start, step_end, last_step;
  logic [IDX_W-1:0]    table_idx, next_idx;
  logic [PERIOD_W-1:0] period_eff;
  logic                timer_load, timer_en, timer_zero;
  logic [PERIOD_W-1:0] timer_load_value;

  assign host_wr    = s_chipselect && !s_write_n;
  assign table_hit  = (s_address >= REG_TABLE_BASE) &&
                      ((s_address - REG_TABLE_BASE) < 4'(DEPTH));
  assign table_idx  = IDX_W'(s_address - REG_TABLE_BASE);
  assign next_idx   = index_q + IDX_W'(1);
  assign period_eff = (period_q == '0) ? PERIOD_W'(1) : period_q;
  assign last_step  = (32'(index_q) + 32'd1) >= 32'(length_q);
  assign start      = host_wr && (s_address == REG_CTRL) &&
                      s_writedata[CTRL_RUN_BIT] && !run_q && (state_q == ST_IDLE);

  pcihellocore_led_seq_timer #(
    .WIDTH (PERIOD_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_load_value),
    .enable     (timer_en),
    .zero       (timer_zero)
  );

  always_comb begin
    state_d          = state_q;
    run_d            = run_q;
    loop_d           = loop_q;
    done_d           = done_q;
    period_d         = period_q;
    length_d         = length_q;
    index_d          = index_q;
    wdata_d          = wdata_q;
    table_d          = table_q;
    timer_load       = 1'b0;
    timer_en         = 1'b0;
    timer_load_value = period_eff - PERIOD_W'(1);
    step_end         = 1'b0;

    if (host_wr) begin
      case (s_address)
        REG_CTRL: begin
          run_d  = s_writedata[CTRL_RUN_BIT];
          loop_d = s_writedata[CTRL_LOOP_BIT];
        end
        REG_PERIOD: period_d = s_writedata[PERIOD_W-1:0];
        REG_LENGTH: begin
          if (s_writedata > 32'(DEPTH)) length_d = LEN_W'(DEPTH);
          else                          length_d = LEN_W'(s_writedata);
        end
        default: begin
          if (table_hit) table_d[table_idx] = s_writedata[DATA_W-1:0];
        end
      endcase
    end

    // FSM clears of run below take priority over a coincident host write.
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          index_d = '0;
          if (length_q != '0) begin
            state_d = ST_WRITE;
            wdata_d = table_q[0];
          end else begin
            done_d = 1'b1;
            run_d  = 1'b0;
          end
        end
      end
      ST_WRITE: begin
        if (!m_waitrequest) begin
          if (!run_q) begin
            state_d = ST_IDLE;
            wdata_d = '0;
          end else if (period_eff == PERIOD_W'(1)) begin
            step_end = 1'b1;
          end else begin
            timer_load = 1'b1;
            state_d    = ST_DWELL;
            wdata_d    = '0;
          end
        end
      end
      ST_DWELL: begin
        timer_en = 1'b1;
        if (!run_q)          state_d  = ST_IDLE;
        else if (timer_zero) step_end = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (step_end) begin
      if (!last_step) begin
        index_d = next_idx;
        state_d = ST_WRITE;
        wdata_d = table_q[next_idx];
      end else if (loop_q) begin
        index_d = '0;
        state_d = ST_WRITE;
        wdata_d = table_q[0];
      end else begin
        done_d  = 1'b1;
        run_d   = 1'b0;
        state_d = ST_IDLE;
        wdata_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      run_q    <= 1'b0;
      loop_q   <= 1'b0;
      done_q   <= 1'b0;
      period_q <= '0;
      length_q <= '0;
      index_q  <= '0;
      wdata_q  <= '0;
      table_q  <= '{default: '0};
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      loop_q   <= loop_d;
      done_q   <= done_d;
      period_q <= period_d;
      length_q <= length_d;
      index_q  <= index_d;
      wdata_q  <= wdata_d;
      table_q  <= table_d;
    end
  end

  always_comb begin
    s_readdata = '0;
    case (s_address)
      REG_CTRL: begin
        s_readdata[CTRL_RUN_BIT]  = run_q;
        s_readdata[CTRL_LOOP_BIT] = loop_q;
      end
      REG_STATUS: begin
        s_readdata[STATUS_BUSY_BIT]         = busy;
        s_readdata[STATUS_DONE_BIT]         = done_q;
        s_readdata[STATUS_INDEX_LSB +: 3]   = 3'(index_q);
      end
      REG_PERIOD: s_readdata[PERIOD_W-1:0] = period_q;
      REG_LENGTH: s_readdata[LEN_W-1:0]    = length_q;
      default: begin
        if (table_hit) s_readdata[DATA_W-1:0] = table_q[table_idx];
      end
    endcase
  end

  assign busy         = (state_q != ST_IDLE);
  assign m_address    = '0;
  assign m_chipselect = (state_q == ST_WRITE);
  assign m_write_n    = (state_q != ST_WRITE);
  assign m_writedata  = wdata_q;

endmodule
